// File: rtl/ffdiv_pkg.sv
// Shared types, constants and field helpers for the iterative single-precision divider.
package ffdiv_pkg;

  localparam int BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StCalc, StRound, StDone} state_e;

  function automatic logic get_sign(input logic [31:0] op);
    return op[31];
  endfunction

  function automatic logic [7:0] get_exp(input logic [31:0] op);
    return op[30:23];
  endfunction

  function automatic logic [22:0] get_frac(input logic [31:0] op);
    return op[22:0];
  endfunction

endpackage

// File: rtl/ffdiv_if.sv
// Operand/result bundle of the divider; master drives operands and start, slave returns the result.
interface ffdiv_if #(
  parameter int unsigned OPERAND_WIDTH     = 32,
  parameter int unsigned EXP_WIDTH         = 8,
  parameter int unsigned SIGNIFICAND_WIDTH = 24
);
  localparam int unsigned CountWidth = $clog2(OPERAND_WIDTH);

  logic [OPERAND_WIDTH-1:0]     op_1;
  logic [OPERAND_WIDTH-1:0]     op_2;
  logic                         div_start;
  logic                         sign;
  logic [EXP_WIDTH-1:0]         biased_exp;
  logic [SIGNIFICAND_WIDTH-2:0] fraction;
  logic                         div_ready;
  logic [CountWidth-1:0]        count;

  modport master (
    output op_1, op_2, div_start,
    input  sign, biased_exp, fraction, div_ready, count
  );

  modport slave (
    input  op_1, op_2, div_start,
    output sign, biased_exp, fraction, div_ready, count
  );
endinterface

// File: rtl/ffdiv_mant_iter.sv
// Restoring mantissa division: one quotient bit per step, remainder/quotient/divisor registers.
module ffdiv_mant_iter #(
  parameter int unsigned SigW  = 24,
  parameter int unsigned QuotW = 26,
  parameter int unsigned CntW  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [SigW:0]    dividend_i,
  input  logic [SigW-1:0]  divisor_i,
  input  logic [CntW-1:0]  bit_idx_i,
  output logic [QuotW-1:0] quot_o,
  output logic             sticky_o,
  output logic             rem_zero_next_o
);

  logic [SigW+1:0]  rem_q, rem_d, rem_step;
  logic [SigW-1:0]  dvs_q, dvs_d;
  logic [QuotW-1:0] quot_q, quot_d;
  logic             ge;

  always_comb begin
    ge       = rem_q >= {2'b00, dvs_q};
    rem_step = (ge ? rem_q - {2'b00, dvs_q} : rem_q) << 1;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    quot_d   = quot_q;
    if (load_i) begin
      rem_d  = {1'b0, dividend_i};
      dvs_d  = divisor_i;
      quot_d = '0;
    end else if (step_i) begin
      rem_d             = rem_step;
      // Bits are placed by position so an early exit leaves the tail at zero.
      quot_d[bit_idx_i] = ge;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quot_q <= quot_d;
    end
  end

  assign quot_o          = quot_q;
  assign sticky_o        = |rem_q;
  assign rem_zero_next_o = (rem_step == '0);

endmodule

// File: rtl/ffdiv_32bit_altr.sv
// Iterative IEEE-754 single-precision divider: special-case decode, FSM, RNE rounding.
module ffdiv_32bit_altr
  import ffdiv_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH     = 32,
  parameter int unsigned EXP_WIDTH         = 8,
  parameter int unsigned SIGNIFICAND_WIDTH = 24,
  parameter int unsigned PRECISION_WIDTH   = SIGNIFICAND_WIDTH + 3
) (
  input logic   clk,
  input logic   rst,
  ffdiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(OPERAND_WIDTH);
  localparam int unsigned QW   = PRECISION_WIDTH - 1;
  localparam int unsigned XW   = EXP_WIDTH + 2;
  localparam int unsigned SigW = SIGNIFICAND_WIDTH;

  state_e state_q, state_d;

  logic                 sign_q, sign_d;
  logic [EXP_WIDTH-1:0] bexp_q, bexp_d;
  logic [SigW-2:0]      frac_q, frac_d;
  logic                 ready_q, ready_d;
  logic [CntW-1:0]      count_q, count_d;
  logic signed [XW-1:0] exp_q, exp_d;

  logic [EXP_WIDTH-1:0] e1, e2;
  logic [SigW-2:0]      f1, f2;
  logic                 z1, z2, inf1, inf2, nan1, nan2;
  logic                 is_nan, is_inf, is_zero, special;
  logic [SigW-1:0]      ma, mb;
  logic                 a_lt_b;
  logic [SigW:0]        dividend;
  logic signed [XW-1:0] e1_s, e2_s, exp_pre;

  logic                 load, step, sticky, rem_zero_next;
  logic [CntW-1:0]      bit_idx;
  logic [QW-1:0]        quot;

  logic [SigW-1:0]      mant;
  logic                 round_up, carry;
  logic [SigW:0]        mant_r;
  logic signed [XW-1:0] exp_r;

  always_comb begin
    e1      = get_exp(bus.op_1);
    e2      = get_exp(bus.op_2);
    f1      = get_frac(bus.op_1);
    f2      = get_frac(bus.op_2);
    // Subnormals count as zero.
    z1      = (e1 == '0);
    z2      = (e2 == '0);
    inf1    = (e1 == '1) && (f1 == '0);
    inf2    = (e2 == '1) && (f2 == '0);
    nan1    = (e1 == '1) && (f1 != '0);
    nan2    = (e2 == '1) && (f2 != '0);
    is_nan  = nan1 | nan2 | (z1 & z2) | (inf1 & inf2);
    is_inf  = z2 | inf1;
    is_zero = z1 | inf2;
    special = is_nan | is_inf | is_zero;
    ma       = {1'b1, f1};
    mb       = {1'b1, f2};
    a_lt_b   = ma < mb;
    dividend = a_lt_b ? {ma, 1'b0} : {1'b0, ma};
    e1_s     = $signed({2'b00, e1});
    e2_s     = $signed({2'b00, e2});
    exp_pre  = e1_s - e2_s + (a_lt_b ? XW'(BIAS - 1) : XW'(BIAS));
  end

  assign load    = (state_q == StIdle) && bus.div_start && !special;
  assign step    = (state_q == StCalc);
  assign bit_idx = CntW'(QW - 1) - count_q;

  ffdiv_mant_iter #(
    .SigW (SigW),
    .QuotW(QW),
    .CntW (CntW)
  ) u_mant_iter (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_i         (load),
    .step_i         (step),
    .dividend_i     (dividend),
    .divisor_i      (mb),
    .bit_idx_i      (bit_idx),
    .quot_o         (quot),
    .sticky_o       (sticky),
    .rem_zero_next_o(rem_zero_next)
  );

  // Round-to-nearest-even on {q[25:0], sticky}: q[1] is guard, q[0]|sticky the rest.
  always_comb begin
    mant     = quot[QW-1:2];
    round_up = quot[1] & (quot[0] | sticky | quot[2]);
    mant_r   = {1'b0, mant} + (SigW + 1)'(round_up);
    carry    = mant_r[SigW];
    exp_r    = exp_q + $signed({{(XW - 1){1'b0}}, carry});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.div_start) state_d = special ? StDone : StCalc;
      StCalc:  if (rem_zero_next || count_q == CntW'(QW - 1)) state_d = StRound;
      StRound: state_d = StDone;
      StDone:  if (!bus.div_start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sign_d  = sign_q;
    bexp_d  = bexp_q;
    frac_d  = frac_q;
    ready_d = ready_q;
    count_d = count_q;
    exp_d   = exp_q;
    unique case (state_q)
      StIdle: begin
        if (bus.div_start) begin
          count_d = '0;
          ready_d = 1'b0;
          sign_d  = get_sign(bus.op_1) ^ get_sign(bus.op_2);
          exp_d   = exp_pre;
          if (is_nan) begin
            sign_d  = get_sign(QNAN);
            bexp_d  = get_exp(QNAN);
            frac_d  = get_frac(QNAN);
            ready_d = 1'b1;
          end else if (is_inf) begin
            bexp_d  = '1;
            frac_d  = '0;
            ready_d = 1'b1;
          end else if (is_zero) begin
            bexp_d  = '0;
            frac_d  = '0;
            ready_d = 1'b1;
          end
        end
      end
      StCalc: count_d = count_q + 1'b1;
      StRound: begin
        ready_d = 1'b1;
        if (exp_r >= XW'(EXP_MAX)) begin
          bexp_d = '1;
          frac_d = '0;
        end else if (exp_r <= 0) begin
          bexp_d = '0;
          frac_d = '0;
        end else begin
          bexp_d = exp_r[EXP_WIDTH-1:0];
          frac_d = carry ? mant_r[SigW-1:1] : mant_r[SigW-2:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q  <= 1'b0;
      bexp_q  <= '0;
      frac_q  <= '0;
      ready_q <= 1'b0;
      count_q <= '0;
      exp_q   <= '0;
    end else begin
      sign_q  <= sign_d;
      bexp_q  <= bexp_d;
      frac_q  <= frac_d;
      ready_q <= ready_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.sign       = sign_q;
  assign bus.biased_exp = bexp_q;
  assign bus.fraction   = frac_q;
  assign bus.div_ready  = ready_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_ffdiv_32bit_altr.sv
// Randomised and directed bench for ffdiv_32bit_altr against an integer-arithmetic division model.
module tb_ffdiv_32bit_altr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ffdiv_if bus ();

  ffdiv_32bit_altr dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_res;
  int          last_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Quotient from exact integer division of the significands; count from divisibility.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cnt, output bit spec);
    logic s, za, zb, ia, ib, na, nb, g, rest;
    longint unsigned ma, mb, num, q, rem, mant;
    int e;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    spec = 1'b1;
    cnt  = 0;
    if (na || nb || (za && zb) || (ia && ib)) res = 32'h7FC0_0000;
    else if (zb || ia)                         res = {s, 8'hFF, 23'd0};
    else if (za || ib)                         res = {s, 31'd0};
    else begin
      spec = 1'b0;
      ma = {40'd1, a[22:0]};
      mb = {40'd1, b[22:0]};
      e  = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (ma < mb) begin
        ma = ma * 2;
        e  = e - 1;
      end
      num  = ma << 25;
      q    = num / mb;
      rem  = num % mb;
      mant = q >> 2;
      g    = q[1];
      rest = q[0] || (rem != 0);
      if (g && (rest || mant[0])) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        e    = e + 1;
      end
      if (e >= 255)    res = {s, 8'hFF, 23'd0};
      else if (e <= 0) res = {s, 31'd0};
      else             res = {s, 8'(e), 23'(mant)};
      cnt = 26;
      for (int k = 1; k <= 26; k++) begin
        if (((ma << (k - 1)) % mb) == 0) begin
          cnt = k;
          break;
        end
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m_res;
    int m_cnt, lat;
    bit m_spec;
    ref_div(a, b, m_res, m_cnt, m_spec);
    @(negedge clk);
    bus.op_1 = a;
    bus.op_2 = b;
    bus.div_start = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    bus.op_1 = $urandom;
    bus.op_2 = $urandom;
    while (!bus.div_ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    last_res = {bus.sign, bus.biased_exp, bus.fraction};
    last_cnt = int'(bus.count);
    check_eq("ready", 64'(bus.div_ready), 64'd1);
    check_eq("result", 64'(last_res), 64'(m_res));
    check_eq("count", 64'(last_cnt), 64'(m_cnt));
    check_eq("latency", 64'(lat), 64'(m_spec ? 1 : m_cnt + 2));
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold", {31'd0, bus.sign, bus.biased_exp, bus.fraction, bus.div_ready, bus.count},
             {31'd0, m_res, 1'b1, 5'(m_cnt)});
    @(negedge clk);
    bus.div_start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_ready", 64'(bus.div_ready), 64'd1);
  endtask

  function automatic logic [31:0] rand_special();
    logic [7:0]  e;
    logic [22:0] f;
    e = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
    f = ($urandom_range(0, 1) == 1) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.op_1 = '0;
    bus.op_2 = '0;
    bus.div_start = 1'b0;
    #1;
    check_eq("reset_out", {31'd0, bus.sign, bus.biased_exp, bus.fraction, bus.div_ready,
             bus.count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'hD0C0_0000, 32'hC03F_FFFF);
    check_eq("tv_sticky_res", 64'(last_res), 64'h5000_0001);
    check_eq("tv_sticky_cnt", 64'(last_cnt), 64'd26);
    run_op(32'h3F80_0000, 32'h4040_0000);
    check_eq("tv_third_res", 64'(last_res), 64'h3EAA_AAAB);
    check_eq("tv_third_cnt", 64'(last_cnt), 64'd26);
    run_op(32'h3F80_0000, 32'h0000_0000);
    check_eq("tv_div0", 64'(last_res), 64'h7F80_0000);
    run_op(32'h0000_0000, 32'h0000_0000);
    check_eq("tv_0div0", 64'(last_res), 64'h7FC0_0000);
    check_eq("tv_0div0_cnt", 64'(last_cnt), 64'd0);
    run_op(32'h8000_0000, 32'h4000_0000);
    check_eq("tv_negzero", 64'(last_res), 64'h8000_0000);
    run_op(32'h7F00_0000, 32'h3E80_0000);
    check_eq("tv_ovf", 64'(last_res), 64'h7F80_0000);
    run_op(32'h0080_0000, 32'h4F00_0000);
    check_eq("tv_unf", 64'(last_res), 64'h0000_0000);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, b;
      int kind;
      kind = $urandom_range(0, 9);
      a = {1'($urandom), 8'($urandom_range(40, 214)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(40, 214)), 23'($urandom)};
      case (kind)
        0: a = rand_special();
        1: b = rand_special();
        2, 3: begin
          a[22:0] = {6'($urandom), 17'd0};
          b[22:0] = {3'($urandom), 20'd0};
        end
        4: begin
          a[30:23] = 8'($urandom_range(200, 254));
          b[30:23] = 8'($urandom_range(1, 60));
        end
        5: begin
          a[30:23] = 8'($urandom_range(1, 60));
          b[30:23] = 8'($urandom_range(200, 254));
        end
        default: ;
      endcase
      run_op(a, b);
    end

    run_op(32'h40C0_0000, 32'h4000_0000);
    check_eq("tv_early_res", 64'(last_res), 64'h4040_0000);
    check_eq("tv_early_cnt", 64'(last_cnt), 64'd2);

    // Abort a 1/3 division in flight.
    @(negedge clk);
    bus.op_1 = 32'h3F80_0000;
    bus.op_2 = 32'h4040_0000;
    bus.div_start = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check_eq("mid_count", 64'(bus.count), 64'd4);
    rst = 1'b1;
    #1;
    check_eq("abort_out", {31'd0, bus.sign, bus.biased_exp, bus.fraction, bus.div_ready,
             bus.count}, 64'd0);
    bus.div_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("abort_idle", {62'd0, bus.div_ready, |bus.count}, 64'd0);
    run_op(32'h3F80_0000, 32'h4040_0000);
    check_eq("tv_recover", 64'(last_res), 64'h3EAA_AAAB);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
